// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the pulse period meter and related GPIO front ends.
package pulse_meter_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    StIdle,
    StMeas,
    StTmo
  } state_t;

  // Default period counter width
  localparam int unsigned PM_CNT_W = 12;

endpackage

// File: rtl/pulse_sync_edge.sv
// Synchronises an asynchronous input and produces a one-cycle rising-edge pulse.
// SYNC_STAGES is meant to be 2 or 3.
module pulse_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Synchroniser chain plus one delay flop on its output for edge detection
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rising edge of the synchronised signal; latency is constant, so periods are exact
  always_comb begin
    rise = sync_q[SYNC_STAGES-1] & ~dly_q;
  end

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the sys_clk cycle count between consecutive rising edges of an
// asynchronous pulse train; reports each period with a one-cycle strobe and
// flags a sticky timeout when no edge arrives within the counter range.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = PM_CNT_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             pulse_in,
  input  logic             clr,
  output logic [CNT_W-1:0] period_out,
  output logic             period_vld,
  output logic             timeout,
  output logic             active
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             rise;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             tmo_q, tmo_d;
  logic             active_q, active_d;

  pulse_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .async_in(pulse_in),
    .rise    (rise)
  );

  // Next-state, counter and output register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    vld_d    = 1'b0;
    tmo_d    = tmo_q;

    if (clr) begin
      // Clear wins over a same-cycle edge; the last period is kept
      state_d = StIdle;
      cnt_d   = '0;
      tmo_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (rise) begin
            cnt_d   = CntOne;
            state_d = StMeas;
          end
        end
        StMeas: begin
          if (rise) begin
            // Edge beats saturation, so a period of exactly CntMax is reported
            period_d = cnt_q;
            vld_d    = 1'b1;
            cnt_d    = CntOne;
          end else if (cnt_q == CntMax) begin
            state_d = StTmo;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StTmo: begin
          // Interval since the previous edge is unknown: restart without a strobe
          if (rise) begin
            tmo_d   = 1'b0;
            cnt_d   = CntOne;
            state_d = StMeas;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    active_d = (state_d == StMeas);
  end

  // State and output registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      tmo_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      tmo_q    <= tmo_d;
      active_q <= active_d;
    end
  end

  // Registered outputs
  always_comb begin
    period_out = period_q;
    period_vld = vld_q;
    timeout    = tmo_q;
    active     = active_q;
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: a default-width instance and a
// CNT_W=4 instance share all inputs; each test checks the relevant one.
module tb_pulse_period_meter;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        pulse_in = 1'b0;
  logic        clr = 1'b0;
  logic [11:0] period_out;
  logic        period_vld, timeout, active;
  logic [3:0]  p4_period;
  logic        p4_vld, p4_timeout, p4_active;

  int nvec = 0;
  int nerr = 0;
  int kk;

  always #5 sys_clk = ~sys_clk;

  pulse_period_meter #(
    .CNT_W      (12),
    .SYNC_STAGES(2)
  ) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .pulse_in  (pulse_in),
    .clr       (clr),
    .period_out(period_out),
    .period_vld(period_vld),
    .timeout   (timeout),
    .active    (active)
  );

  pulse_period_meter #(
    .CNT_W      (4),
    .SYNC_STAGES(2)
  ) u_dut4 (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .pulse_in  (pulse_in),
    .clr       (clr),
    .period_out(p4_period),
    .period_vld(p4_vld),
    .timeout   (p4_timeout),
    .active    (p4_active)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst  = 1'b1;
    pulse_in = 1'b0;
    clr      = 1'b0;
    repeat (2) tick();
    sys_rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    sys_rst  = 1'b1;
    pulse_in = 1'b0;
    clr      = 1'b0;
    repeat (3) tick();
    nvec++;
    if ({period_out, period_vld, timeout, active} !== 15'h0) begin
      nerr++;
      $display("FAIL reset_w12 got po=%0d vld=%b tmo=%b act=%b exp all 0",
               period_out, period_vld, timeout, active);
    end
    nvec++;
    if ({p4_period, p4_vld, p4_timeout, p4_active} !== 7'h0) begin
      nerr++;
      $display("FAIL reset_w4 got po=%0d vld=%b tmo=%b act=%b exp all 0",
               p4_period, p4_vld, p4_timeout, p4_active);
    end
    sys_rst = 1'b0;
    repeat (3) tick();
    nvec++;
    if ({period_out, period_vld, timeout, active} !== 15'h0) begin
      nerr++;
      $display("FAIL reset_release got po=%0d vld=%b tmo=%b act=%b exp all 0",
               period_out, period_vld, timeout, active);
    end
  endtask

  // 1-cycle pulse every 5 cycles, 20 pulses
  task automatic test_period5();
    int  exp_per;
    bit  ev;
    do_reset();
    exp_per = 0;
    for (int k = 0; k < 100; k++) begin
      pulse_in = (k % 5 == 0);
      tick();
      kk = k + 1;
      ev = (kk >= 8) && ((kk - 3) % 5 == 0) && (kk - 3 <= 95);
      if (ev) exp_per = 5;
      nvec++;
      if (period_vld !== ev) begin
        nerr++;
        $display("FAIL p5_vld k=%0d got %b exp %b", kk, period_vld, ev);
      end
      nvec++;
      if (period_out !== 12'(exp_per)) begin
        nerr++;
        $display("FAIL p5_period k=%0d got %0d exp %0d", kk, period_out, exp_per);
      end
      nvec++;
      if (active !== (kk >= 3) || timeout !== 1'b0) begin
        nerr++;
        $display("FAIL p5_status k=%0d got act=%b tmo=%b exp act=%b tmo=0",
                 kk, active, timeout, (kk >= 3));
      end
    end
    pulse_in = 1'b0;
  endtask

  // Period 2 (fastest), then period 1024
  task automatic test_fast_slow();
    int raises[$];
    int exp_per;
    bit r, ev;
    do_reset();
    for (int i = 0; i < 10; i++) raises.push_back(2 * i);
    raises.push_back(1042);
    raises.push_back(2066);
    raises.push_back(3090);
    exp_per = 0;
    for (int k = 0; k < 3095; k++) begin
      r = 1'b0;
      foreach (raises[i]) if (raises[i] == k) r = 1'b1;
      pulse_in = r;
      tick();
      kk = k + 1;
      ev = 1'b0;
      for (int j = 1; j < raises.size(); j++) begin
        if (raises[j] + 3 == kk) begin
          ev      = 1'b1;
          exp_per = raises[j] - raises[j-1];
        end
      end
      nvec++;
      if (period_vld !== ev) begin
        nerr++;
        $display("FAIL fs_vld k=%0d got %b exp %b", kk, period_vld, ev);
      end
      nvec++;
      if (period_out !== 12'(exp_per) || timeout !== 1'b0) begin
        nerr++;
        $display("FAIL fs_period k=%0d got %0d tmo=%b exp %0d tmo=0",
                 kk, period_out, timeout, exp_per);
      end
    end
    pulse_in = 1'b0;
  endtask

  // CNT_W=4: period 7, timeout, restart from TMO, period 9
  task automatic test_timeout();
    int raises[$] = '{0, 7, 40, 49};
    int exp_per;
    bit r, ev, et, ea;
    do_reset();
    exp_per = 0;
    for (int k = 0; k < 56; k++) begin
      r = 1'b0;
      foreach (raises[i]) if (raises[i] == k) r = 1'b1;
      pulse_in = r;
      tick();
      kk = k + 1;
      ev = (kk == 10) || (kk == 52);
      if (kk == 10) exp_per = 7;
      if (kk == 52) exp_per = 9;
      et = (kk >= 25) && (kk < 43);
      ea = ((kk >= 3) && (kk < 25)) || (kk >= 43);
      nvec++;
      if (p4_vld !== ev) begin
        nerr++;
        $display("FAIL tmo_vld k=%0d got %b exp %b", kk, p4_vld, ev);
      end
      nvec++;
      if (p4_period !== 4'(exp_per)) begin
        nerr++;
        $display("FAIL tmo_period k=%0d got %0d exp %0d", kk, p4_period, exp_per);
      end
      nvec++;
      if (p4_timeout !== et) begin
        nerr++;
        $display("FAIL tmo_flag k=%0d got %b exp %b", kk, p4_timeout, et);
      end
      nvec++;
      if (p4_active !== ea) begin
        nerr++;
        $display("FAIL tmo_active k=%0d got %b exp %b", kk, p4_active, ea);
      end
    end
    pulse_in = 1'b0;
  endtask

  // CNT_W=4: edges exactly 15 apart, edge beats saturation
  task automatic test_saturation_edge();
    int exp_per;
    bit ev;
    do_reset();
    exp_per = 0;
    for (int k = 0; k < 36; k++) begin
      pulse_in = (k == 0) || (k == 15) || (k == 30);
      tick();
      kk = k + 1;
      ev = (kk == 18) || (kk == 33);
      if (ev) exp_per = 15;
      nvec++;
      if (p4_vld !== ev || p4_period !== 4'(exp_per)) begin
        nerr++;
        $display("FAIL sat_period k=%0d got vld=%b po=%0d exp vld=%b po=%0d",
                 kk, p4_vld, p4_period, ev, exp_per);
      end
      nvec++;
      if (p4_timeout !== 1'b0 || p4_active !== (kk >= 3)) begin
        nerr++;
        $display("FAIL sat_status k=%0d got tmo=%b act=%b exp tmo=0 act=%b",
                 kk, p4_timeout, p4_active, (kk >= 3));
      end
    end
    pulse_in = 1'b0;
  endtask

  // clr mid-measurement (with W4 in timeout) and clr colliding with an edge
  task automatic test_clr();
    int raises[$] = '{0, 5, 40, 47, 60, 70, 76};
    int exp_per;
    bit r, ev, ea12, ea4, et4;
    do_reset();
    exp_per = 0;
    for (int k = 0; k < 85; k++) begin
      r = 1'b0;
      foreach (raises[i]) if (raises[i] == k) r = 1'b1;
      pulse_in = r;
      clr      = (k == 30) || (k == 62);
      tick();
      kk = k + 1;
      ev = (kk == 8) || (kk == 50) || (kk == 79);
      if (kk == 8)  exp_per = 5;
      if (kk == 50) exp_per = 7;
      if (kk == 79) exp_per = 6;
      ea12 = ((kk >= 3) && (kk < 31)) || ((kk >= 43) && (kk < 63)) || (kk >= 73);
      ea4  = ((kk >= 3) && (kk < 23)) || ((kk >= 43) && (kk < 63)) || (kk >= 73);
      et4  = (kk >= 23) && (kk < 31);
      nvec++;
      if (period_vld !== ev || period_out !== 12'(exp_per)) begin
        nerr++;
        $display("FAIL clr_w12_period k=%0d got vld=%b po=%0d exp vld=%b po=%0d",
                 kk, period_vld, period_out, ev, exp_per);
      end
      nvec++;
      if (active !== ea12 || timeout !== 1'b0) begin
        nerr++;
        $display("FAIL clr_w12_status k=%0d got act=%b tmo=%b exp act=%b tmo=0",
                 kk, active, timeout, ea12);
      end
      nvec++;
      if (p4_vld !== ev || p4_period !== 4'(exp_per)) begin
        nerr++;
        $display("FAIL clr_w4_period k=%0d got vld=%b po=%0d exp vld=%b po=%0d",
                 kk, p4_vld, p4_period, ev, exp_per);
      end
      nvec++;
      if (p4_active !== ea4 || p4_timeout !== et4) begin
        nerr++;
        $display("FAIL clr_w4_status k=%0d got act=%b tmo=%b exp act=%b tmo=%b",
                 kk, p4_active, p4_timeout, ea4, et4);
      end
    end
    pulse_in = 1'b0;
    clr      = 1'b0;
  endtask

  // Asynchronous reset between clock edges, then a fresh measurement
  task automatic test_async_reset();
    bit ev;
    int exp_per;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      pulse_in = (k == 0) || (k == 4);
      tick();
    end
    nvec++;
    if (p4_timeout !== 1'b1 || period_out !== 12'd4 || active !== 1'b1) begin
      nerr++;
      $display("FAIL arst_pre got tmo4=%b po=%0d act=%b exp tmo4=1 po=4 act=1",
               p4_timeout, period_out, active);
    end
    #2;
    sys_rst = 1'b1;
    #1;
    nvec++;
    if ({period_out, period_vld, timeout, active} !== 15'h0) begin
      nerr++;
      $display("FAIL arst_w12 got po=%0d vld=%b tmo=%b act=%b exp all 0",
               period_out, period_vld, timeout, active);
    end
    nvec++;
    if ({p4_period, p4_vld, p4_timeout, p4_active} !== 7'h0) begin
      nerr++;
      $display("FAIL arst_w4 got po=%0d vld=%b tmo=%b act=%b exp all 0",
               p4_period, p4_vld, p4_timeout, p4_active);
    end
    tick();
    sys_rst = 1'b0;
    tick();
    exp_per = 0;
    for (int k = 0; k < 12; k++) begin
      pulse_in = (k == 0) || (k == 6);
      tick();
      kk = k + 1;
      ev = (kk == 9);
      if (ev) exp_per = 6;
      nvec++;
      if (period_vld !== ev || period_out !== 12'(exp_per)) begin
        nerr++;
        $display("FAIL arst_after k=%0d got vld=%b po=%0d exp vld=%b po=%0d",
                 kk, period_vld, period_out, ev, exp_per);
      end
      nvec++;
      if (p4_vld !== ev || p4_period !== 4'(exp_per)) begin
        nerr++;
        $display("FAIL arst_after_w4 k=%0d got vld=%b po=%0d exp vld=%b po=%0d",
                 kk, p4_vld, p4_period, ev, exp_per);
      end
    end
    pulse_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_period5();
    test_fast_slow();
    test_timeout();
    test_saturation_edge();
    test_clr();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
